// File: rtl/rv_seq_pkg.sv
// Shared types for the multicycle load sequencer.
// Provides state and op-class encodings and the active level of the load strobes.
package rv_seq_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXECUTE = 4'd3,
    MEM     = 4'd4,
    WB      = 4'd5,
    COMMIT  = 4'd6,
    HALT    = 4'd7,
    FAULT   = 4'd8
  } seq_state_t;

  typedef enum logic [2:0] {
    ALU_R   = 3'd0,
    ALU_I   = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    JAL     = 3'd5,
    SYSTEM  = 3'd6,
    ILLEGAL = 3'd7
  } op_class_t;

  localparam logic LD_ACTIVE = 1'b0;
  localparam logic LD_IDLE   = 1'b1;

endpackage

// File: rtl/load_sequencer_wait_timer.sv
// Counts consecutive memory-wait cycles; o_tc flags the cycle that is the TIMEOUT_CYCLES-th wait.
// Zero-latency terminal count; i_clr (any state change) restarts the count.
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/load_sequencer.sv
// Multicycle fetch/decode/execute/mem/writeback sequencer driving active-low datapath load strobes.
// Strobes decode combinationally from the registered state; memory stalls hold FETCH/MEM until mem_rdy_i or timeout.
module load_sequencer
  import rv_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic [2:0]  op_class_i,
  input  logic        br_taken_i,
  input  logic        mem_rdy_i,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        pc_ld_o,
  output logic        ir_ld_o,
  output logic        mdr_ld_o,
  output logic        a_ld_o,
  output logic        b_ld_o,
  output logic        alu_ld_o,
  output logic        rf_wr_o,
  output logic        pc_sel_o,
  output logic [3:0]  state_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] instret_o
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  op_class_t  w_op;
  logic       w_wait;
  logic       w_tc;
  logic       w_retire;
  logic [31:0] r_instret;

  assign w_op   = op_class_t'(op_class_i);
  assign w_wait = ((r_state == FETCH) || (r_state == MEM)) && !mem_rdy_i;

  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_clr   (w_state_nxt != r_state),
    .i_en    (w_wait),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    pc_ld_o     = LD_IDLE;
    ir_ld_o     = LD_IDLE;
    mdr_ld_o    = LD_IDLE;
    a_ld_o      = LD_IDLE;
    b_ld_o      = LD_IDLE;
    alu_ld_o    = LD_IDLE;
    rf_wr_o     = LD_IDLE;
    pc_sel_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (run_i) w_state_nxt = FETCH;
      end
      FETCH: begin
        mem_rd_o = 1'b1;
        if (mem_rdy_i) begin
          ir_ld_o     = LD_ACTIVE;
          w_state_nxt = DECODE;
        end else if (w_tc) begin
          w_state_nxt = FAULT;
        end
      end
      DECODE: begin
        a_ld_o = LD_ACTIVE;
        b_ld_o = LD_ACTIVE;
        case (w_op)
          SYSTEM:  w_state_nxt = HALT;
          ILLEGAL: w_state_nxt = FAULT;
          default: w_state_nxt = EXECUTE;
        endcase
      end
      EXECUTE: begin
        alu_ld_o = LD_ACTIVE;
        case (w_op)
          LOAD, STORE:       w_state_nxt = MEM;
          ALU_R, ALU_I, JAL: w_state_nxt = WB;
          BRANCH:            w_state_nxt = COMMIT;
          default:           w_state_nxt = FAULT;
        endcase
      end
      MEM: begin
        // Only LOAD/STORE can reach MEM; anything else means the IR changed underneath us.
        if (w_op == LOAD) begin
          mem_rd_o = 1'b1;
          if (mem_rdy_i) begin
            mdr_ld_o    = LD_ACTIVE;
            w_state_nxt = WB;
          end else if (w_tc) begin
            w_state_nxt = FAULT;
          end
        end else if (w_op == STORE) begin
          mem_wr_o = 1'b1;
          if (mem_rdy_i) begin
            w_state_nxt = COMMIT;
          end else if (w_tc) begin
            w_state_nxt = FAULT;
          end
        end else begin
          w_state_nxt = FAULT;
        end
      end
      WB: begin
        rf_wr_o     = LD_ACTIVE;
        w_state_nxt = COMMIT;
      end
      COMMIT: begin
        pc_ld_o     = LD_ACTIVE;
        pc_sel_o    = ((w_op == BRANCH) && br_taken_i) || (w_op == JAL);
        w_retire    = 1'b1;
        w_state_nxt = run_i ? FETCH : IDLE;
      end
      HALT:    w_state_nxt = HALT;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = FAULT;
    endcase
  end

  assign state_o   = r_state;
  assign halted_o  = (r_state == HALT);
  assign fault_o   = (r_state == FAULT);
  assign instret_o = r_instret;

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: per-instruction cycle plans built from the class rules, replayed against the DUT.
// Every cycle compares the full output bundle against the planned expectation.
module tb_load_sequencer;
  import rv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        run_i = 1'b0;
  logic [2:0]  op_class_i = 3'd0;
  logic        br_taken_i = 1'b0;
  logic        mem_rdy_i = 1'b0;
  logic        mem_rd_o, mem_wr_o, pc_ld_o, ir_ld_o, mdr_ld_o, a_ld_o, b_ld_o;
  logic        alu_ld_o, rf_wr_o, pc_sel_o, halted_o, fault_o;
  logic [3:0]  state_o;
  logic [31:0] instret_o;

  always #5 clk = ~clk;

  load_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .run_i(run_i), .op_class_i(op_class_i),
    .br_taken_i(br_taken_i), .mem_rdy_i(mem_rdy_i),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .pc_ld_o(pc_ld_o), .ir_ld_o(ir_ld_o),
    .mdr_ld_o(mdr_ld_o), .a_ld_o(a_ld_o), .b_ld_o(b_ld_o), .alu_ld_o(alu_ld_o),
    .rf_wr_o(rf_wr_o), .pc_sel_o(pc_sel_o), .state_o(state_o), .halted_o(halted_o),
    .fault_o(fault_o), .instret_o(instret_o)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        rd;
    logic        wr;
    logic [6:0]  ld_n;   // {pc, ir, mdr, a, b, alu, rf}
    logic        pc_sel;
    logic        halted;
    logic        fault;
    logic [31:0] instret;
  } obs_t;

  typedef struct packed {
    logic       rdy;
    logic       run;
    logic       rst;
    logic [2:0] cls;
    logic       taken;
  } stim_t;

  localparam logic [6:0] M_NONE = 7'b0000000;
  localparam logic [6:0] M_PC   = 7'b1000000;
  localparam logic [6:0] M_IR   = 7'b0100000;
  localparam logic [6:0] M_MDR  = 7'b0010000;
  localparam logic [6:0] M_AB   = 7'b0001100;
  localparam logic [6:0] M_ALU  = 7'b0000010;
  localparam logic [6:0] M_RF   = 7'b0000001;

  obs_t  exp_q[$];
  stim_t stim_q[$];
  obs_t  obs;
  logic [31:0] m_instret = '0;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string tname = "init";

  assign obs = {state_o, mem_rd_o, mem_wr_o,
                {pc_ld_o, ir_ld_o, mdr_ld_o, a_ld_o, b_ld_o, alu_ld_o, rf_wr_o},
                pc_sel_o, halted_o, fault_o, instret_o};

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [2:0] rcls();
    return 3'($urandom);
  endfunction

  function automatic void push(seq_state_t st, logic rd, logic wr, logic [6:0] low,
                               logic psel, logic rdy, logic run, logic rst,
                               logic [2:0] cls, logic taken);
    obs_t  e;
    stim_t s;
    e.st      = st;
    e.rd      = rd;
    e.wr      = wr;
    e.ld_n    = ~low;
    e.pc_sel  = psel;
    e.halted  = (st == HALT);
    e.fault   = (st == FAULT);
    e.instret = m_instret;
    s.rdy = rdy; s.run = run; s.rst = rst; s.cls = cls; s.taken = taken;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endfunction

  // A cycle in a state whose outputs ignore memory/class inputs: randomise those.
  function automatic void passive(seq_state_t st, logic run, logic rst);
    push(st, 1'b0, 1'b0, M_NONE, 1'b0, rb(), run, rst, rcls(), rb());
  endfunction

  function automatic void plan_instr(op_class_t cls, int fw, int mw, logic taken, logic run_end);
    logic is_ld;
    logic is_st;
    is_ld = (cls == LOAD);
    is_st = (cls == STORE);
    for (int i = 0; i < fw; i++) push(FETCH, 1'b1, 1'b0, M_NONE, 1'b0, 1'b0, 1'b1, 1'b0, rcls(), taken);
    push(FETCH, 1'b1, 1'b0, M_IR, 1'b0, 1'b1, 1'b1, 1'b0, rcls(), taken);
    push(DECODE, 1'b0, 1'b0, M_AB, 1'b0, rb(), 1'b1, 1'b0, cls, taken);
    if (cls == SYSTEM || cls == ILLEGAL) return;
    push(EXECUTE, 1'b0, 1'b0, M_ALU, 1'b0, rb(), 1'b1, 1'b0, cls, taken);
    if (is_ld || is_st) begin
      for (int i = 0; i < mw; i++) push(MEM, is_ld, is_st, M_NONE, 1'b0, 1'b0, 1'b1, 1'b0, cls, taken);
      push(MEM, is_ld, is_st, is_ld ? M_MDR : M_NONE, 1'b0, 1'b1, 1'b1, 1'b0, cls, taken);
    end
    if (cls != STORE && cls != BRANCH) push(WB, 1'b0, 1'b0, M_RF, 1'b0, rb(), 1'b1, 1'b0, cls, taken);
    push(COMMIT, 1'b0, 1'b0, M_PC, ((cls == BRANCH) && taken) || (cls == JAL),
         rb(), run_end, 1'b0, cls, taken);
    m_instret = m_instret + 32'd1;
  endfunction

  task automatic drain();
    obs_t  e;
    stim_t s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      @(posedge clk);
      #1;
      mem_rdy_i  = s.rdy;
      run_i      = s.run;
      reset_i    = s.rst;
      op_class_i = s.cls;
      br_taken_i = s.taken;
      #2;
      cyc++;
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", tname, cyc, obs, e);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);

    tname = "reset_alu_r";
    passive(IDLE, 1'b0, 1'b1);
    passive(IDLE, 1'b0, 1'b0);
    passive(IDLE, 1'b1, 1'b0);
    plan_instr(ALU_R, 0, 0, 1'b0, 1'b1);
    drain();

    tname = "load_wait2";
    plan_instr(LOAD, 2, 2, 1'b0, 1'b1);
    drain();

    tname = "branch";
    plan_instr(BRANCH, 0, 0, 1'b1, 1'b1);
    plan_instr(BRANCH, 0, 0, 1'b0, 1'b1);
    plan_instr(JAL, 0, 0, 1'b0, 1'b1);
    drain();

    tname = "random_mix";
    for (int n = 0; n < 30; n++) begin
      logic run_end;
      run_end = ($urandom_range(0, 3) != 0);
      plan_instr(op_class_t'($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3), rb(), run_end);
      if (!run_end) begin
        for (int k = 0; k < $urandom_range(0, 2); k++) passive(IDLE, 1'b0, 1'b0);
        passive(IDLE, 1'b1, 1'b0);
      end
    end
    drain();

    tname = "wait_15_completes";
    plan_instr(LOAD, 15, 15, 1'b0, 1'b1);
    plan_instr(STORE, 0, 15, 1'b0, 1'b1);
    drain();

    tname = "run_low_commit";
    plan_instr(ALU_I, 1, 0, 1'b0, 1'b0);
    passive(IDLE, 1'b0, 1'b0);
    passive(IDLE, 1'b0, 1'b0);
    passive(IDLE, 1'b1, 1'b0);
    drain();

    tname = "system_halt";
    plan_instr(SYSTEM, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) passive(HALT, rb(), 1'b0);
    passive(HALT, 1'b1, 1'b1);
    m_instret = '0;
    passive(IDLE, 1'b1, 1'b0);
    drain();

    tname = "illegal_fault";
    plan_instr(ILLEGAL, 1, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) passive(FAULT, rb(), 1'b0);
    passive(FAULT, 1'b1, 1'b1);
    m_instret = '0;
    passive(IDLE, 1'b1, 1'b0);
    drain();

    tname = "fetch_timeout";
    plan_instr(STORE, 0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) push(FETCH, 1'b1, 1'b0, M_NONE, 1'b0, 1'b0, 1'b1, 1'b0, rcls(), rb());
    for (int k = 0; k < 3; k++) passive(FAULT, rb(), 1'b0);
    passive(FAULT, 1'b1, 1'b1);
    m_instret = '0;
    passive(IDLE, 1'b1, 1'b0);
    drain();

    tname = "reset_mid_store";
    plan_instr(ALU_R, 0, 0, 1'b0, 1'b1);
    push(FETCH, 1'b1, 1'b0, M_IR, 1'b0, 1'b1, 1'b1, 1'b0, rcls(), 1'b0);
    push(DECODE, 1'b0, 1'b0, M_AB, 1'b0, rb(), 1'b1, 1'b0, STORE, 1'b0);
    push(EXECUTE, 1'b0, 1'b0, M_ALU, 1'b0, rb(), 1'b1, 1'b0, STORE, 1'b0);
    push(MEM, 1'b0, 1'b1, M_NONE, 1'b0, 1'b0, 1'b1, 1'b0, STORE, 1'b0);
    push(MEM, 1'b0, 1'b1, M_NONE, 1'b0, 1'b0, 1'b1, 1'b1, STORE, 1'b0);
    m_instret = '0;
    passive(IDLE, 1'b0, 1'b0);
    passive(IDLE, 1'b0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
